// File: rtl/uart_rx_pkg.sv
// Shared configuration for the UART receiver: FSM state type, default
// divisor and FIFO depth, plus the parity-check helper used by the decoder.
package uart_rx_pkg;

  // Receiver frame-decoding states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Default divisor: clocks per bit minus 1 (115200 baud at 25 MHz).
  localparam int CLKS_PER_BIT = 216;

  // Default FIFO depth exponent (2**FIFO_LOG entries).
  localparam int FIFO_LOG_DEF = 4;

  // Default divisor width.
  localparam int DIV_W_DEF = 16;

  // Parity error: data bits XOR received parity bit must equal the odd flag.
  // Narrower data words are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_err(input logic [7:0] data,
                                      input logic       sample,
                                      input logic       odd);
    return (((^data) ^ sample) != odd);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO holding received frames {ferr, perr, data}.
// A push that finds the FIFO full with no same-cycle pop is dropped and
// raises the sticky overrun flag; clr clears it unless a drop happens in
// the same cycle.
module uart_fifo #(
  parameter int WIDTH    = 10,
  parameter int FIFO_LOG = 4
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_push_data,
  input  logic                i_pop,
  input  logic                i_clr,
  output logic [WIDTH-1:0]    o_head,
  output logic                o_valid,
  output logic [FIFO_LOG:0]   o_count,
  output logic                o_overrun
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] C_FULL  = (FIFO_LOG+1)'(DEPTH);
  localparam logic [FIFO_LOG:0] C_EMPTY = (FIFO_LOG+1)'(0);
  localparam logic [FIFO_LOG:0] C_ONE   = (FIFO_LOG+1)'(1);
  localparam logic [FIFO_LOG-1:0] C_PTR_ONE = FIFO_LOG'(1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [FIFO_LOG-1:0] r_rd_ptr;
  logic [FIFO_LOG-1:0] r_wr_ptr;
  logic [FIFO_LOG:0]   r_count;
  logic                r_overrun;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  // Decide which of push/pop actually take effect this cycle.
  always_comb begin
    w_full    = (r_count == C_FULL);
    w_empty   = (r_count == C_EMPTY);
    w_do_pop  = i_pop & ~w_empty;
    w_do_push = i_push & (~w_full | w_do_pop);
    w_drop    = i_push & w_full & ~w_do_pop;
  end

  // Storage array; cleared on reset so the head reads as zero when empty.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_rd_ptr <= {FIFO_LOG{1'b0}};
      r_wr_ptr <= {FIFO_LOG{1'b0}};
      r_count  <= C_EMPTY;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun: a drop in the same cycle as clr keeps the flag set.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_valid   = ~w_empty;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/parity/stop decoder with
// per-frame latched configuration, and a FWFT FIFO of received frames.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FIFO_LOG = FIFO_LOG_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                reset,
  input  logic                clock,
  input  logic                rx,
  input  logic [DIV_W-1:0]    div,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                stop2,
  input  logic                rd_en,
  input  logic                clr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_perr,
  output logic                rd_ferr,
  output logic                rd_valid,
  output logic [FIFO_LOG:0]   count,
  output logic                overrun
);

  localparam logic [2:0]       C_BIT_LAST = 3'(DATA_W - 1);
  localparam logic [DIV_W-1:0] C_CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] C_CNT_ZERO = DIV_W'(0);

  // Synchroniser and edge detector
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;

  // Decoder state and per-frame configuration
  state_e            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_par_en;
  logic              r_par_odd;
  logic              r_stop2;
  logic [2:0]        r_bit_idx;
  logic              r_stop_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_perr;
  logic              r_ferr;
  logic              r_wait_high;

  logic                w_fall;
  logic                w_sample;
  logic                w_final_ferr;
  logic                w_push;
  logic [DATA_W+1:0]   w_push_word;
  logic [DATA_W+1:0]   w_head;

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Falling-edge detect, sample strobe and the frame-complete push.
  always_comb begin
    w_fall = r_rx_prev & ~r_rx_sync;
    case (r_state)
      ST_START:                     w_sample = (r_cnt == (r_div >> 1));
      ST_DATA, ST_PARITY, ST_STOP:  w_sample = (r_cnt == r_div);
      default:                      w_sample = 1'b0;
    endcase
    w_final_ferr = r_ferr | ~r_rx_sync;
    if ((r_state == ST_STOP) && w_sample && (!r_stop2 || r_stop_idx)) begin
      w_push = 1'b1;
    end else begin
      w_push = 1'b0;
    end
    w_push_word = {w_final_ferr, r_perr, r_shift};
  end

  // Frame decoder: walks start, data, optional parity and stop bits.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_div       <= C_CNT_ZERO;
      r_cnt       <= C_CNT_ZERO;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_bit_idx   <= 3'd0;
      r_stop_idx  <= 1'b0;
      r_shift     <= {DATA_W{1'b0}};
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_wait_high <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= C_CNT_ZERO;
          // After a framing error the line must return high before a new
          // start is accepted, so a held break cannot re-trigger.
          if (r_rx_sync) begin
            r_wait_high <= 1'b0;
          end else begin
            r_wait_high <= r_wait_high;
          end
          if (w_fall && !r_wait_high) begin
            r_state    <= ST_START;
            r_div      <= div;
            r_par_en   <= parity_en;
            r_par_odd  <= parity_odd;
            r_stop2    <= stop2;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_START: begin
          if (w_sample) begin
            r_cnt <= C_CNT_ZERO;
            // A high mid-start sample is a glitch: abandon quietly.
            if (r_rx_sync) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        ST_DATA: begin
          if (w_sample) begin
            r_cnt   <= C_CNT_ZERO;
            r_shift <= {r_rx_sync, r_shift[DATA_W-1:1]};
            if (r_bit_idx == C_BIT_LAST) begin
              r_bit_idx <= 3'd0;
              if (r_par_en) begin
                r_state <= ST_PARITY;
              end else begin
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (w_sample) begin
            r_cnt   <= C_CNT_ZERO;
            r_perr  <= parity_err(8'(r_shift), r_rx_sync, r_par_odd);
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        ST_STOP: begin
          if (w_sample) begin
            r_cnt <= C_CNT_ZERO;
            if (r_stop2 && !r_stop_idx) begin
              r_ferr     <= w_final_ferr;
              r_stop_idx <= 1'b1;
            end else begin
              r_ferr      <= w_final_ferr;
              r_wait_high <= w_final_ferr;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= C_CNT_ZERO;
        end
      endcase
    end
  end

  uart_fifo #(
    .WIDTH    (DATA_W + 2),
    .FIFO_LOG (FIFO_LOG)
  ) u_fifo (
    .i_clock     (clock),
    .i_reset_n   (reset),
    .i_push      (w_push),
    .i_push_data (w_push_word),
    .i_pop       (rd_en),
    .i_clr       (clr),
    .o_head      (w_head),
    .o_valid     (rd_valid),
    .o_count     (count),
    .o_overrun   (overrun)
  );

  assign rd_data = w_head[DATA_W-1:0];
  assign rd_perr = w_head[DATA_W];
  assign rd_ferr = w_head[DATA_W+1];

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based reference model of
// the receiver FIFO contents and overrun flag.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int DATA_W   = 8;
  localparam int FIFO_LOG = 2;
  localparam int DIV_W    = 16;
  localparam int DEPTH    = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              rx = 1'b1;
  logic [DIV_W-1:0]  div = 16'd216;
  logic              parity_en = 1'b0;
  logic              parity_odd = 1'b0;
  logic              stop2 = 1'b0;
  logic              rd_en = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr;
  logic              rd_ferr;
  logic              rd_valid;
  logic [FIFO_LOG:0] count;
  logic              overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queued frames {ferr, perr, data} and sticky overrun.
  logic [9:0] model_q[$];
  logic       model_ovr = 1'b0;

  uart_rx #(.DATA_W(DATA_W), .FIFO_LOG(FIFO_LOG), .DIV_W(DIV_W)) dut (
    .reset(reset), .clock(clock), .rx(rx), .div(div),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rd_en(rd_en), .clr(clr), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .rd_valid(rd_valid), .count(count), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive one frame bit-by-bit (bit time = d+1 clocks), then update model.
  task automatic send_frame(input logic [7:0] data, input logic pen, input logic podd,
                            input logic pbit, input logic s2, input logic sb1,
                            input logic sb2, input int d, input logic scramble);
    logic [9:0] w;
    logic       ferr;
    logic       perr;
    div = 16'(d); parity_en = pen; parity_odd = podd; stop2 = s2;
    rx = 1'b1; tick(20);
    rx = 1'b0; tick(d + 1);
    if (scramble) begin
      div = 16'($urandom_range(5, 200));
      parity_en = ~pen; parity_odd = ~podd; stop2 = ~s2;
    end
    for (int i = 0; i < 8; i++) begin
      rx = data[i]; tick(d + 1);
    end
    if (pen) begin
      rx = pbit; tick(d + 1);
    end
    rx = sb1; tick(d + 1);
    if (s2) begin
      rx = sb2; tick(d + 1);
    end
    rx = 1'b1;
    ferr = (sb1 == 1'b0) || (s2 && (sb2 == 1'b0));
    perr = pen && ((($countones(data) + int'(pbit)) % 2) != int'(podd));
    w = {ferr, perr, data};
    if (model_q.size() == DEPTH) model_ovr = 1'b1;
    else model_q.push_back(w);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
    chk({tag, "_ovr"}, 32'(overrun), 32'(model_ovr));
  endtask

  // Compare the head against the model, then request a pop.
  task automatic pop_check(input string tag);
    logic [9:0] h;
    if (model_q.size() == 0) begin
      chk({tag, "_valid"}, 32'(rd_valid), 32'(0));
    end else begin
      h = model_q.pop_front();
      chk({tag, "_valid"}, 32'(rd_valid), 32'(1));
      chk({tag, "_data"}, 32'(rd_data), 32'(h[7:0]));
      chk({tag, "_perr"}, 32'(rd_perr), 32'(h[8]));
      chk({tag, "_ferr"}, 32'(rd_ferr), 32'(h[9]));
    end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask

  initial begin
    int d;
    logic [7:0] data;
    logic pen, podd, pbit, s2, sb1, sb2, scr;

    // Reset state
    reset = 1'b0; tick(3);
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    reset = 1'b1; tick(2);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check_state("rst");

    // 8N1 0xA5 at div=216
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 216, 1'b0);
    chk("a5_count1", 32'(count), 32'(1));
    check_state("a5");
    pop_check("a5");
    check_state("a5_after_pop");

    // Even parity, 0x07 with parity bit 0 -> parity error
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 216, 1'b0);
    chk("par_perr_direct", 32'(rd_perr), 32'(1));
    check_state("par");
    pop_check("par");

    // Two stop bits, second bad, then a clean 0x55
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 216, 1'b0);
    chk("stop2_ferr_direct", 32'(rd_ferr), 32'(1));
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 216, 1'b0);
    check_state("stop2");
    pop_check("stop2_a");
    pop_check("stop2_b");

    // 50-cycle glitch is a false start
    div = 16'd216; rx = 1'b1; tick(20);
    rx = 1'b0; tick(50);
    rx = 1'b1; tick(300);
    chk("glitch_state", 32'(dut.r_state), 32'(ST_IDLE));
    check_state("glitch");

    // Pop on empty is ignored
    pop_check("empty_pop");
    check_state("empty_pop");

    // Overrun with a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40, 1'b0);
    end
    chk("ovr_count4", 32'(count), 32'(4));
    chk("ovr_flag", 32'(overrun), 32'(1));
    for (int i = 1; i <= 4; i++) pop_check("ovr_pop");
    check_state("ovr_drained");
    clr = 1'b1; tick(1); clr = 1'b0; model_ovr = 1'b0;
    check_state("ovr_clr");

    // Reset during data bits
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40, 1'b0);
    rx = 1'b1; tick(20);
    rx = 1'b0; tick(41);
    rx = 1'b1; tick(41);
    rx = 1'b0; tick(20);
    reset = 1'b0; tick(1);
    chk("midrst_rd_data", 32'(rd_data), 32'(0));
    chk("midrst_count", 32'(count), 32'(0));
    rx = 1'b1; tick(1);
    reset = 1'b1;
    model_q.delete(); model_ovr = 1'b0;
    tick(2);
    check_state("midrst");
    send_frame(8'h9E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40, 1'b0);
    check_state("midrst_next");
    pop_check("midrst_next");

    // Randomized frames
    for (int it = 0; it < 24; it++) begin
      d    = int'($urandom_range(15, 60));
      data = 8'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      s2   = 1'($urandom_range(0, 1));
      sb1  = ($urandom_range(0, 5) != 0);
      sb2  = ($urandom_range(0, 5) != 0);
      scr  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) pop_check("rnd_pop");
      send_frame(data, pen, podd, pbit, s2, sb1, sb2, d, scr);
      check_state("rnd");
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1; tick(1); clr = 1'b0; model_ovr = 1'b0;
        check_state("rnd_clr");
      end
    end
    while (model_q.size() != 0) pop_check("drain");
    check_state("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
